store_narrow_buffer: RTL and testbench
======================================

STORE_NARROW_BUFFER -- requirements
Module: store_narrow_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queued store entries, a power of two and at least 2.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  store request present.
REQ-005 SHALL have port in_ready  output  1  buffer can accept a request this cycle.
REQ-006 SHALL have port in_addr  input  32  byte address of the store.
REQ-007 SHALL have port in_data  input  32  store data; the payload sits in the low bits.
REQ-008 SHALL have port in_size  input  2  store size: 00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-009 SHALL have port mem_valid  output  1  head entry presented to memory.
REQ-010 SHALL have port mem_ready  input  1  memory accepts the head entry.
REQ-011 SHALL have port mem_addr  output  32  word address of the head entry; bits [1:0] are always 0.
REQ-012 SHALL have port mem_wdata  output  32  lane-replicated write data.
REQ-013 SHALL have port mem_be  output  4  byte enables; bit i enables byte lane i (bits [8i+7:8i]).
REQ-014 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.
REQ-015 SHALL have port full  output  1  count equals DEPTH.
REQ-016 SHALL have port empty  output  1  count equals 0.
REQ-017 SHALL have port misalign  output  1  misaligned-request pulse; tied to 0 unless MISALIGN_TRAP_EN is defined.

Function
REQ-018 SHALL drive in_ready = !full combinationally; no bypass, so a dequeue in the same cycle does not free the slot while the buffer is full.
REQ-019 SHALL enqueue on a rising edge where in_valid && in_ready, and dequeue on a rising edge where mem_valid && mem_ready.
REQ-020 SHALL hold count unchanged on a simultaneous enqueue and dequeue; write and read pointers wrap modulo DEPTH.
REQ-021 SHALL narrow a byte store: wdata = {4{in_data[7:0]}}, be = 4'b0001 << in_addr[1:0].
REQ-022 SHALL narrow a halfword store: wdata = {2{in_data[15:0]}}, be = in_addr[1] ? 4'b1100 : 4'b0011.
REQ-023 SHALL pass a word store (size 10 or 11) unchanged: wdata = in_data, be = 4'b1111.
REQ-024 SHALL store {in_addr[31:2], 2'b00} as the entry address.
REQ-025 SHALL compute and store all narrowing at enqueue; mem_* SHALL be driven from registered storage only, with no combinational path from the in_* ports to the mem_* ports.
REQ-026 SHALL show an entry accepted at edge N on mem_* from cycle N+1 when the buffer was empty (latency 1).
REQ-027 SHALL drive mem_valid = !empty; while mem_valid && !mem_ready, mem_addr, mem_wdata and mem_be SHALL hold stable.
REQ-028 SHALL drive mem_addr, mem_wdata and mem_be to 0 while mem_valid = 0.
REQ-029 SHALL present entries in strict FIFO order; no merging or reordering.

Reset
REQ-030 SHALL, on a rising edge with rst = 1, clear both pointers and the count, which gives in_ready = 1, mem_valid = 0, empty = 1, full = 0, count = 0, misalign = 0 and mem_* = 0.
REQ-031 SHALL give rst priority over a simultaneous enqueue or dequeue; entries queued before a mid-operation reset SHALL be discarded and never presented.
REQ-032 SHALL leave the storage array unreset.

Configuration
REQ-033 SHALL, with MISALIGN_TRAP_EN defined, treat a halfword with in_addr[0] = 1, or a word with in_addr[1:0] != 0, as misaligned.
REQ-034 SHALL, under MISALIGN_TRAP_EN, complete the handshake for a misaligned request, not enqueue it, and pulse misalign high for exactly the one cycle after acceptance.
REQ-035 SHALL, without MISALIGN_TRAP_EN, ignore misalignment: halfword lane select uses in_addr[1] only, word stores ignore in_addr[1:0], every request is enqueued, and misalign = 0.

Verification
REQ-036 SHALL cover: byte store addr 0x1003, data 0x000000AB, mem_ready = 1 -> next cycle mem_addr 0x1000, wdata 0xABABABAB, be 1000.
REQ-037 SHALL cover: halfword store addr 0x2002, data 0x1234 -> wdata 0x12341234, be 1100; word store addr 0x2000 -> be 1111, wdata equal to in_data.
REQ-038 SHALL cover: mem_ready = 0, 5 back-to-back requests, DEPTH 4 -> full = 1 and in_ready = 0 after 4 accepts; raising mem_ready drains the 4 entries in order.
REQ-039 SHALL cover: simultaneous enqueue and dequeue at count 2 -> count stays 2 and order is preserved.
REQ-040 SHALL cover: rst = 1 with 3 entries queued -> next cycle empty = 1, mem_valid = 0, mem_* = 0.
REQ-041 SHALL cover, with MISALIGN_TRAP_EN: word store at 0x3001 -> accepted, count unchanged, misalign high for 1 cycle; without the macro -> enqueued with be 1111 at mem_addr 0x3000.

Source files
------------

// File: rtl/store_narrow_buffer.sv
// Store narrowing FIFO: lane-replicates byte/halfword stores and queues them for memory.
// Optional MISALIGN_TRAP_EN: misaligned requests are accepted, dropped, and flagged on misalign.
module store_narrow_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_addr,
  input  logic [31:0]              in_data,
  input  logic [1:0]               in_size,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     misalign
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [31:0] addr_mem  [DEPTH];
  logic [31:0] wdata_mem [DEPTH];
  logic [3:0]  be_mem    [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;

  logic [31:0] nar_wdata;
  logic [3:0]  nar_be;
  logic        mis_req;
  logic        accept, push, pop;

  always_comb begin
    nar_wdata = in_data;
    nar_be    = 4'b1111;
    case (in_size)
      2'b00: begin
        nar_wdata = {4{in_data[7:0]}};
        nar_be    = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        nar_wdata = {2{in_data[15:0]}};
        nar_be    = in_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        nar_wdata = in_data;
        nar_be    = 4'b1111;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  always_comb begin
    mis_req = 1'b0;
    if (in_size == 2'b01) begin
      mis_req = in_addr[0];
    end else if (in_size[1]) begin
      mis_req = (in_addr[1:0] != 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= accept && mis_req;
    end
  end

  assign misalign = misalign_q;
`else
  assign mis_req  = 1'b0;
  assign misalign = 1'b0;
`endif

  assign full     = (count_q == CntW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign in_ready = !full;

  assign accept = in_valid && in_ready;
  assign push   = accept && !mis_req;
  assign pop    = mem_valid && mem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is intentionally unreset; pointers/count alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q]  <= {in_addr[31:2], 2'b00};
      wdata_mem[wr_ptr_q] <= nar_wdata;
      be_mem[wr_ptr_q]    <= nar_be;
    end
  end

  assign mem_valid = !empty;
  assign mem_addr  = mem_valid ? addr_mem[rd_ptr_q]  : 32'h0;
  assign mem_wdata = mem_valid ? wdata_mem[rd_ptr_q] : 32'h0;
  assign mem_be    = mem_valid ? be_mem[rd_ptr_q]    : 4'h0;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Self-checking bench for store_narrow_buffer: vector table, corner sequences, random vs queue model.
module tb_store_narrow_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        misalign;

  store_narrow_buffer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_size   (in_size),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } ent_t;

  ent_t q[$];
  logic exp_mis = 1'b0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference narrowing, computed from lane arithmetic rather than shifts/concats.
  function automatic ent_t model_narrow(input logic [31:0] a, input logic [31:0] d,
                                        input logic [1:0] s);
    ent_t r;
    int   lane;
    r.addr = a & 32'hFFFF_FFFC;
    r.be   = 4'h0;
    if (s == 2'd0) begin
      r.wdata = {24'h0, d[7:0]} * 32'h0101_0101;
      lane    = int'(a % 4);
      r.be[lane] = 1'b1;
    end else if (s == 2'd1) begin
      r.wdata = {16'h0, d[15:0]} * 32'h0001_0001;
      lane    = int'(a % 4) & 2;
      r.be[lane]     = 1'b1;
      r.be[lane + 1] = 1'b1;
    end else begin
      r.wdata = d;
      r.be    = 4'hF;
    end
    return r;
  endfunction

  function automatic logic model_mis(input logic [31:0] a, input logic [1:0] s);
`ifdef MISALIGN_TRAP_EN
    if (s == 2'd1) return (a % 2) != 0;
    if (s >= 2'd2) return (a % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    ent_t h;
    check("count", count, q.size());
    check("empty", empty, q.size() == 0);
    check("full", full, q.size() == DEPTH);
    check("in_ready", in_ready, q.size() < DEPTH);
    check("mem_valid", mem_valid, q.size() != 0);
    check("misalign", misalign, exp_mis);
    if (q.size() != 0) h = q[0];
    else h = '0;
    check("mem_addr", mem_addr, h.addr);
    check("mem_wdata", mem_wdata, h.wdata);
    check("mem_be", mem_be, h.be);
  endtask

  // Compare current outputs with the model, advance the model, then cross one edge.
  task automatic tick();
    logic acc, mis;
    check_outputs();
    if (rst) begin
      q.delete();
      exp_mis = 1'b0;
    end else begin
      acc = in_valid && (q.size() < DEPTH);
      mis = model_mis(in_addr, in_size);
      if (q.size() != 0 && mem_ready) void'(q.pop_front());
      if (acc && !mis) q.push_back(model_narrow(in_addr, in_data, in_size));
      exp_mis = acc && mis;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    mem_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    exp_mis = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  initial begin
    vt[0] = '{32'h1003, 32'h0000_00AB, 2'd0, 32'h1000, 32'hABAB_ABAB, 4'b1000};
    vt[1] = '{32'h2002, 32'h0000_1234, 2'd1, 32'h2000, 32'h1234_1234, 4'b1100};
    vt[2] = '{32'h2000, 32'hDEAD_BEEF, 2'd2, 32'h2000, 32'hDEAD_BEEF, 4'b1111};
    vt[3] = '{32'h4001, 32'hFFFF_FF5A, 2'd0, 32'h4000, 32'h5A5A_5A5A, 4'b0010};
    vt[4] = '{32'h4000, 32'hCAFE_9876, 2'd1, 32'h4000, 32'h9876_9876, 4'b0011};
    vt[5] = '{32'h5004, 32'h0123_4567, 2'd3, 32'h5004, 32'h0123_4567, 4'b1111};

    drive(1'b0, 32'h0, 32'h0, 2'd0);
    do_reset();
    check("rst_count", count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_misalign", misalign, 0);
    check("rst_mem_addr", mem_addr, 0);

    // Vector table: single store into empty buffer, visible next cycle.
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vt[i].addr, vt[i].data, vt[i].size);
      mem_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("vec_mem_valid", mem_valid, 1);
      check("vec_mem_addr", mem_addr, vt[i].e_addr);
      check("vec_mem_wdata", mem_wdata, vt[i].e_wdata);
      check("vec_mem_be", mem_be, vt[i].e_be);
      tick();
      check("vec_drained", empty, 1);
    end

    // Fill with memory stalled; fifth request must be refused, then drain in order.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + 32'(4 * i), 32'h11 * 32'(i + 1), 2'd2);
      if (i == 4) begin
        check("fill_full", full, 1);
        check("fill_in_ready", in_ready, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    check("fill_count", count, 4);
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_order", mem_wdata, 32'h11 * 32'(i + 1));
      tick();
    end
    check("drain_empty", empty, 1);

    // Simultaneous enqueue/dequeue at count 2.
    do_reset();
    drive(1'b1, 32'h600, 32'hA, 2'd2);
    tick();
    drive(1'b1, 32'h604, 32'hB, 2'd2);
    tick();
    drive(1'b1, 32'h608, 32'hC, 2'd2);
    mem_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("simul_count", count, 2);
    check("simul_head", mem_wdata, 32'hB);
    tick();
    check("simul_next", mem_wdata, 32'hC);
    tick();
    check("simul_empty", empty, 1);

    // Reset with three entries queued, and enqueue/dequeue requested alongside.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + 32'(4 * i), 32'h70 + 32'(i), 2'd2);
      tick();
    end
    rst       = 1'b1;
    in_valid  = 1'b1;
    mem_ready = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("rst3_empty", empty, 1);
    check("rst3_mem_valid", mem_valid, 0);
    check("rst3_mem_addr", mem_addr, 0);
    check("rst3_mem_wdata", mem_wdata, 0);
    check("rst3_mem_be", mem_be, 0);
    tick();
    check("rst3_discarded", mem_valid, 0);

    // Misaligned word store at 0x3001.
    do_reset();
`ifdef MISALIGN_TRAP_EN
    drive(1'b1, 32'h800, 32'h5, 2'd2);
    tick();
    drive(1'b1, 32'h3001, 32'h6, 2'd2);
    check("mis_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("mis_count", count, 1);
    check("mis_pulse", misalign, 1);
    tick();
    check("mis_pulse_end", misalign, 0);
    check("mis_count_after", count, 1);
`else
    drive(1'b1, 32'h3001, 32'h6, 2'd2);
    tick();
    in_valid = 1'b0;
    check("mis_count", count, 1);
    check("mis_addr", mem_addr, 32'h3000);
    check("mis_be", mem_be, 4'hF);
    check("mis_low", misalign, 0);
`endif
    tick();

    // Randomised traffic against the queue model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst       = ($urandom_range(0, 79) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      mem_ready = $urandom_range(0, 2) != 0;
      in_addr   = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
      in_data   = $urandom;
      in_size   = 2'($urandom_range(0, 3));
      tick();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
